acc_exec_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute controller for the accumulator CPU, sitting on the driving side of the ALU. It holds the accumulator, a 4x8 register file, the PC and the Z/C flags. It drives the ALU operands and select, and captures the result and flags. Instructions are fetched over a req/ack read port.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/acc_regfile.sv | 45 ++++
 rtl/acc_exec_ctrl.sv | 170 +++++++++++++++++
 tb/tb_acc_exec_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU.
// The opcode encoding lives here so the ALU and the execute controller
// agree on a single set of values. It also holds the controller FSM state
// type, the instruction field positions and a few decode helpers.
package cpu_pkg;

    localparam int DATA_W = 8;

    // Instruction byte layout: [7:4] opcode, [3:2] reserved, [1:0] rs
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RS_LO  = 0;

    // Opcodes executed by the ALU
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVR = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;

    // Opcodes handled entirely by the controller
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MOVA = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_JC   = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_LDI  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1010;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_OPFETCH = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_NOR, OP_MOVR, OP_SHL, OP_SHR};
    endfunction

    // Instructions whose second byte is an immediate or a jump target
    function automatic logic is_two_byte(input logic [3:0] op);
        return op inside {OP_LDI, OP_JMP, OP_JZ, OP_JC};
    endfunction

endpackage

// File: rtl/acc_regfile.sv
// General-purpose register file for the accumulator CPU.
// NREG x 8-bit registers, one synchronous write port, one asynchronous
// read port, all registers cleared by the synchronous reset.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   we/waddr/wdata  write port (takes effect at the rising edge)
//   raddr/rdata     combinational read port
module acc_regfile
    import cpu_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

endmodule

// File: rtl/acc_exec_ctrl.sv
// Fetch/decode/execute controller for the accumulator CPU.
// Holds ACC, the register file, PC and the Z/C flags. It fetches
// instruction bytes over a req/ack read port, drives the external ALU
// during EXEC and captures its result and flags.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req/imem_addr               read request and address (= pc)
//   imem_ack/imem_data               read data valid and data
//   alu_accum/alu_in/alu_sel         ALU operands (ACC, R[rs]) and opcode
//   alu_result/alu_z/alu_c           ALU result and flags
//   acc, pc, zf, cf, halted          architectural state
module acc_exec_ctrl
    import cpu_pkg::*;
#(
    parameter int         NREG     = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] alu_accum,
    output logic [7:0] alu_in,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_z,
    input  logic       alu_c,
    output logic [7:0] acc,
    output logic [7:0] pc,
    output logic       zf,
    output logic       cf,
    output logic       halted
);

    localparam int IDX_W = $clog2(NREG);

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       acc_q, acc_d;
    logic [3:0]       ir_op_q, ir_op_d;
    logic [IDX_W-1:0] ir_rs_q, ir_rs_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             boot_q, boot_d;
    logic             rf_we;
    logic [7:0]       rf_rdata;
    logic [7:0]       pc_inc;

    acc_regfile #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (ir_rs_q),
        .wdata (acc_q),
        .raddr (ir_rs_q),
        .rdata (rf_rdata)
    );

    // 8-bit add wraps FF->00 on its own, including between the two bytes of an instruction
    assign pc_inc = pc_q + 8'd1;

    // Next-state and output logic. boot_q holds the request low for one
    // cycle after reset, so an ack that straddles reset can never be
    // taken as the answer to a fresh fetch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        ir_op_d  = ir_op_q;
        ir_rs_d  = ir_rs_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        boot_d   = 1'b0;
        imem_req = 1'b0;
        alu_sel  = OP_NOP;
        rf_we    = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (!boot_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_op_d = imem_data[OPC_HI:OPC_LO];
                        ir_rs_d = imem_data[RS_LO +: IDX_W];
                        pc_d    = pc_inc;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (is_alu_op(ir_op_q)) begin
                    state_d = ST_EXEC;
                end else if (is_two_byte(ir_op_q)) begin
                    state_d = ST_OPFETCH;
                end else if (ir_op_q == OP_MOVA) begin
                    rf_we   = 1'b1;
                    state_d = ST_FETCH;
                end else if (ir_op_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_sel = ir_op_q;
                acc_d   = alu_result;
                zf_d    = alu_z;
                cf_d    = alu_c;
                state_d = ST_FETCH;
            end
            ST_OPFETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_d = pc_inc;
                    case (ir_op_q)
                        OP_LDI: begin
                            acc_d = imem_data;
                            zf_d  = (imem_data == 8'h00);
                        end
                        OP_JMP: pc_d = imem_data;
                        OP_JZ:  if (zf_q) pc_d = imem_data;
                        OP_JC:  if (cf_q) pc_d = imem_data;
                        default: ;
                    endcase
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // State register; reset takes priority over any handshake in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            acc_q   <= 8'h00;
            ir_op_q <= OP_NOP;
            ir_rs_q <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_op_q <= ir_op_d;
            ir_rs_q <= ir_rs_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            boot_q  <= boot_d;
        end
    end

    assign imem_addr = pc_q;
    assign alu_accum = acc_q;
    assign alu_in    = rf_rdata;
    assign acc       = acc_q;
    assign pc        = pc_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Testbench for acc_exec_ctrl. The bench plays both the instruction memory
// (with configurable ack delay and stray acks while no request is pending)
// and the ALU. An instruction-level model of the CPU predicts, for each
// program, the ordered list of memory addresses read, the ALU operations
// with their operands, and the final architectural state.
module tb_acc_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic [7:0] alu_accum, alu_in;
   logic [3:0] alu_sel;
   logic [7:0] alu_result;
   logic       alu_z, alu_c;
   logic [7:0] acc, pc;
   logic       zf, cf, halted;

   int numAsserts = 0;
   int numFails = 0;

   logic [7:0]  mem [256];
   logic [7:0]  addrQ [$];
   logic [19:0] aluQ [$];
   logic [7:0]  expAcc, expPc;
   logic        expZf, expCf;

   int         fixedDelay = 0;
   int         maxDelay = 0;
   bit         pending = 1'b0;
   int         waitLeft = 0;
   logic [7:0] heldAddr = 8'h00;
   logic [3:0] prevSel = 4'h0;

   always #5 clk = ~clk;

   acc_exec_ctrl #(.NREG(4), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .alu_accum(alu_accum), .alu_in(alu_in), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c),
      .acc(acc), .pc(pc), .zf(zf), .cf(cf), .halted(halted)
   );

   // ALU stand-in: 9-bit result, carry is bit 8; unlisted selects return
   // garbage so that sampling outside EXEC corrupts the state visibly
   logic [8:0] aluWide;
   logic       aluKnown;
   always_comb begin
      aluWide = 9'h000;
      aluKnown = 1'b1;
      case (alu_sel)
         4'b0001: aluWide = {1'b0, alu_accum} + {1'b0, alu_in};
         4'b0010: aluWide = {1'b0, alu_accum} - {1'b0, alu_in};
         4'b0011: aluWide = {1'b0, ~(alu_accum | alu_in)};
         4'b0100: aluWide = {1'b0, alu_in};
         4'b1011: aluWide = {alu_accum, 1'b0};
         4'b1100: aluWide = {2'b00, alu_accum[7:1]};
         default: aluKnown = 1'b0;
      endcase
      alu_result = aluKnown ? aluWide[7:0] : 8'h5A;
      alu_z = aluKnown ? (aluWide[7:0] == 8'h00) : 1'b1;
      alu_c = aluKnown ? aluWide[8] : 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numAsserts++;
      assert (observed === expected) else begin
         numFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Instruction-level model: walks the program byte by byte
   task automatic modelRun(output bit ok);
      logic [7:0] r [4];
      logic [7:0] a, p, opnd, b;
      logic [3:0] op;
      logic [1:0] rs;
      bit z, c, done;
      addrQ.delete();
      aluQ.delete();
      for (int i = 0; i < 4; i++) r[i] = 8'h00;
      a = 8'h00; p = 8'h00; z = 1'b0; c = 1'b0; done = 1'b0;
      for (int step = 0; step < 400 && !done; step++) begin
         addrQ.push_back(p);
         op = mem[p][7:4];
         rs = mem[p][1:0];
         p = p + 8'd1;
         b = r[rs];
         case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12: begin
               aluQ.push_back({op, a, b});
               if (op == 4'd1) begin
                  c = (int'(a) + int'(b)) > 255; a = 8'(int'(a) + int'(b));
               end else if (op == 4'd2) begin
                  c = a < b; a = 8'(int'(a) - int'(b));
               end else if (op == 4'd3) begin
                  c = 1'b0; a = ~(a | b);
               end else if (op == 4'd4) begin
                  c = 1'b0; a = b;
               end else if (op == 4'd11) begin
                  c = a[7]; a = 8'(int'(a) * 2);
               end else begin
                  c = 1'b0; a = 8'(int'(a) / 2);
               end
               z = (a == 8'h00);
            end
            4'd5: r[rs] = a;
            4'd6, 4'd7, 4'd8, 4'd9: begin
               addrQ.push_back(p);
               opnd = mem[p];
               p = p + 8'd1;
               if (op == 4'd9) begin
                  a = opnd; z = (opnd == 8'h00);
               end else if (op == 4'd8 || (op == 4'd6 && z) || (op == 4'd7 && c)) begin
                  p = opnd;
               end
            end
            4'd10: done = 1'b1;
            default: ;
         endcase
      end
      expAcc = a; expPc = p; expZf = z; expCf = c;
      ok = done;
   endtask

   // One clock of environment: observe the ALU port, answer memory requests
   task automatic applyStimulus();
      logic [19:0] e;
      logic [7:0] expAddr;
      @(negedge clk);
      if (alu_sel !== 4'b0000) begin
         checkOutput("alu_sel_single_cycle", 32'(prevSel), 32'h0);
         checkOutput("alu_op_expected", 32'(aluQ.size() != 0), 32'h1);
         if (aluQ.size() != 0) begin
            e = aluQ.pop_front();
            checkOutput("alu_sel", 32'(alu_sel), 32'(e[19:16]));
            checkOutput("alu_accum", 32'(alu_accum), 32'(e[15:8]));
            checkOutput("alu_in", 32'(alu_in), 32'(e[7:0]));
         end
      end
      prevSel = alu_sel;
      if (imem_req !== 1'b1) begin
         if (pending) checkOutput("imem_req_held", 32'(imem_req), 32'h1);
         pending = 1'b0;
         imem_ack = ($urandom_range(0, 3) == 0);
         imem_data = 8'($urandom);
      end else begin
         if (!pending) begin
            pending = 1'b1;
            heldAddr = imem_addr;
            waitLeft = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, maxDelay));
         end else begin
            checkOutput("imem_addr_stable", 32'(imem_addr), 32'(heldAddr));
         end
         if (waitLeft == 0) begin
            imem_ack = 1'b1;
            imem_data = mem[imem_addr];
            pending = 1'b0;
            checkOutput("fetch_expected", 32'(addrQ.size() != 0), 32'h1);
            if (addrQ.size() != 0) begin
               expAddr = addrQ.pop_front();
               checkOutput("fetch_addr", 32'(imem_addr), 32'(expAddr));
            end
         end else begin
            imem_ack = 1'b0;
            imem_data = 8'($urandom);
            waitLeft--;
         end
      end
   endtask

   // Reset for one edge, optionally with an ack arriving alongside rst and
   // again just after it; both must be ignored
   task automatic doReset(input bit ackAround, input logic [7:0] lateData);
      @(negedge clk);
      rst = 1'b1;
      imem_ack = ackAround;
      imem_data = lateData;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_pc", 32'(pc), 32'h00);
      checkOutput("rst_acc", 32'(acc), 32'h00);
      checkOutput("rst_zf", 32'(zf), 32'h0);
      checkOutput("rst_cf", 32'(cf), 32'h0);
      checkOutput("rst_halted", 32'(halted), 32'h0);
      checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
      checkOutput("rst_alu_sel", 32'(alu_sel), 32'h0);
      pending = 1'b0;
      prevSel = 4'h0;
   endtask

   task automatic runToHalt(input int holdCycles);
      for (int cyc = 0; cyc < 3000 && halted !== 1'b1; cyc++) applyStimulus();
      checkOutput("halt_within_budget", 32'(halted), 32'h1);
      checkOutput("final_acc", 32'(acc), 32'(expAcc));
      checkOutput("final_pc", 32'(pc), 32'(expPc));
      checkOutput("final_zf", 32'(zf), 32'(expZf));
      checkOutput("final_cf", 32'(cf), 32'(expCf));
      checkOutput("fetches_left", 32'(addrQ.size()), 32'h0);
      checkOutput("alu_ops_left", 32'(aluQ.size()), 32'h0);
      for (int i = 0; i < holdCycles; i++) begin
         applyStimulus();
         checkOutput("halt_stays", 32'(halted), 32'h1);
         checkOutput("halt_req_low", 32'(imem_req), 32'h0);
         checkOutput("halt_pc_frozen", 32'(pc), 32'(expPc));
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 8'hA0;
   endtask

   task automatic runDirected(input int delay, input int holdCycles);
      bit ok;
      fixedDelay = delay;
      modelRun(ok);
      checkOutput("model_halts", 32'(ok), 32'h1);
      doReset(1'b1, 8'h90);
      runToHalt(holdCycles);
   endtask

   task automatic genProgram();
      int len, i;
      logic [3:0] op;
      clearMem();
      len = $urandom_range(16, 48);
      i = 0;
      while (i < len - 2) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'd10) op = 4'd9;
         mem[i] = {op, 2'($urandom), 2'($urandom)};
         if (op >= 4'd6 && op <= 4'd9) begin
            if (op == 4'd9) mem[i + 1] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            else mem[i + 1] = 8'($urandom_range(i + 2, len));
            i += 2;
         end else begin
            i += 1;
         end
      end
   endtask

   initial begin
      bit ok;
      $display("[TB] start");
      clearMem();
      repeat (2) @(negedge clk);
      doReset(1'b0, 8'h00);

      // Reset mid-FETCH with an ack arriving together with rst
      mem[0] = 8'h90; mem[1] = 8'h55; mem[2] = 8'hA0;
      fixedDelay = 3;
      modelRun(ok);
      for (int cyc = 0; cyc < 60 && acc !== 8'h55; cyc++) applyStimulus();
      checkOutput("t1_ldi_loaded", 32'(acc), 32'h55);
      doReset(1'b1, 8'hA0);
      fixedDelay = 0;
      modelRun(ok);
      runToHalt(2);
      checkOutput("t1_refetch_acc", 32'(acc), 32'h55);
      checkOutput("t1_refetch_pc", 32'(pc), 32'h03);

      // LDI 05; MOVA R1; LDI 03; SUB R1; HALT, zero wait then 5-cycle wait
      for (int d = 0; d <= 5; d += 5) begin
         clearMem();
         mem[0] = 8'h90; mem[1] = 8'h05; mem[2] = 8'h51;
         mem[3] = 8'h90; mem[4] = 8'h03; mem[5] = 8'h21;
         runDirected(d, 2);
         checkOutput("t2_acc", 32'(acc), 32'hFE);
         checkOutput("t2_cf", 32'(cf), 32'h1);
         checkOutput("t2_zf", 32'(zf), 32'h0);
         checkOutput("t2_pc", 32'(pc), 32'h07);
      end

      // LDI 80; SHL R0; JZ 40
      clearMem();
      mem[0] = 8'h90; mem[1] = 8'h80; mem[2] = 8'hB0; mem[3] = 8'h60; mem[4] = 8'h40;
      runDirected(0, 2);
      checkOutput("t3_acc", 32'(acc), 32'h00);
      checkOutput("t3_zf", 32'(zf), 32'h1);
      checkOutput("t3_cf", 32'(cf), 32'h1);
      checkOutput("t3_pc", 32'(pc), 32'h41);

      // JC at 10 with carry clear falls through to 12
      clearMem();
      mem[0] = 8'h80; mem[1] = 8'h10; mem[16] = 8'h70; mem[17] = 8'h20;
      runDirected(0, 2);
      checkOutput("t4_jc_not_taken_pc", 32'(pc), 32'h13);

      // Same JC with carry set (LDI 80; SHL) is taken to 20
      mem[0] = 8'h90; mem[1] = 8'h80; mem[2] = 8'hB0; mem[3] = 8'h80; mem[4] = 8'h10;
      runDirected(2, 2);
      checkOutput("t4_jc_taken_pc", 32'(pc), 32'h21);

      // LDI at FF takes its operand from 00; then NOP at 01 and HALT at 02
      clearMem();
      mem[0] = 8'h80; mem[1] = 8'hFF; mem[255] = 8'h90;
      runDirected(1, 20);
      checkOutput("t6_acc", 32'(acc), 32'h80);
      checkOutput("t6_pc", 32'(pc), 32'h03);

      // Random forward-flowing programs with random ack delays
      fixedDelay = -1;
      maxDelay = 3;
      for (int n = 0; n < 16; n++) begin
         ok = 1'b0;
         for (int t = 0; t < 50 && !ok; t++) begin
            genProgram();
            modelRun(ok);
         end
         checkOutput("rand_model_halts", 32'(ok), 32'h1);
         doReset(1'b1, 8'($urandom));
         runToHalt(3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
      $finish;
   end

endmodule
